// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer with AXI-Stream output register
//
// Purpose: synchronises rxd, detects the start edge, drives the prescaler enable and
// samples start/data/[parity]/stop bits on the prescaler mid-bit strobe. A finished
// byte is loaded into a one-entry AXI-Stream output register; framing and overrun
// conditions are reported as single-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rxd             asynchronous serial input, idle high
//   pre_en          prescaler enable (prescaler counter held at 0 while low)
//   pre_stb         prescaler end-of-bit strobe (only checked, never used by datapath)
//   pre_half        prescaler mid-bit strobe, sample point
//   m_axis_tdata    received data, LSB first on the line
//   m_axis_tvalid   output register holds an unconsumed byte
//   m_axis_tready   downstream accept
//   frame_err       1-cycle pulse, a stop bit was sampled low
//   overrun         1-cycle pulse, byte completed while output register was full
//   parity_odd      (UART_RX_PARITY_EN) 1: odd parity, 0: even parity
//   parity_err      (UART_RX_PARITY_EN) 1-cycle pulse, parity mismatch

module uart_rx_deframer #(
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic                 pre_en,
   input  logic                 pre_stb,
   input  logic                 pre_half,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_RX_PARITY_EN
   ,
   input  logic                 parity_odd,
   output logic                 parity_err
`endif
);

   localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxd_q, rxd_d;
   logic                   rxd_s;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   ferr_q, ferr_d;
   logic                   pre_en_q, pre_en_d;
   logic [DATA_BITS-1:0]   tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   ferr_next;
   logic                   discard;
`ifdef UART_RX_PARITY_EN
   logic                   perr_q, perr_d;
   logic                   parity_err_q, parity_err_d;
`endif

   assign rxd_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d       = {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_d        = rxd_s;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shreg_d      = shreg_q;
      ferr_d       = ferr_q;
      tdata_d      = tdata_q;
      // A handshake empties the register; a completion in the same cycle may reload it.
      tvalid_d     = tvalid_q & ~m_axis_tready;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      ferr_next    = ferr_q;
      discard      = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d       = perr_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (rxd_q && !rxd_s) begin
               state_d = S_START;
               ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d  = 1'b0;
`endif
            end
         end
         S_START: begin
            if (pre_half) begin
               if (!rxd_s) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end else begin
                  // Start bit vanished by mid-bit: treat as a glitch.
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (pre_half) begin
               shreg_d[bit_cnt_q] = rxd_s;
               bit_cnt_d          = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                  stop_cnt_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                  state_d    = S_PARITY;
`else
                  state_d    = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (pre_half) begin
               if (rxd_s != ((^shreg_q) ^ parity_odd)) begin
                  perr_d = 1'b1;
               end
               stop_cnt_d = 1'b0;
               state_d    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (pre_half) begin
               ferr_next = ferr_q | ~rxd_s;
               ferr_d    = ferr_next;
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  discard = ferr_next;
`ifdef UART_RX_PARITY_EN
                  discard      = ferr_next | perr_q;
                  parity_err_d = perr_q;
`endif
                  if (discard) begin
                     frame_err_d = ferr_next;
                  end else if (tvalid_q && !m_axis_tready) begin
                     overrun_d = 1'b1;
                  end else begin
                     tdata_d  = shreg_q;
                     tvalid_d = 1'b1;
                  end
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      pre_en_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sync_q       <= '1;
         rxd_q        <= 1'b1;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         shreg_q      <= '0;
         ferr_q       <= 1'b0;
         pre_en_q     <= 1'b0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q       <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         rxd_q        <= rxd_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         shreg_q      <= shreg_d;
         ferr_q       <= ferr_d;
         pre_en_q     <= pre_en_d;
         tdata_q      <= tdata_d;
         tvalid_q     <= tvalid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         perr_q       <= perr_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // pre_en drops one cycle after the last mid-bit sample, well before the
   // prescaler can reach its end-of-bit count, so pre_stb never arrives in IDLE.
   a_no_stb_in_idle: assert property (@(posedge clk) disable iff (rst)
      !(pre_stb && state_q == S_IDLE));

   assign pre_en        = pre_en_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign frame_err     = frame_err_q;
   assign overrun       = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed self-checking bench for uart_rx_deframer

module tb_uart_rx_deframer;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic       pre_en;
   logic       pre_stb;
   logic       pre_half;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_odd;
   logic       parity_err;
   logic       par_force;
   logic       par_v;
`endif

   int checks;
   int failures;

   int got_cnt;
   int vcyc;
   int fe_cnt;
   int ov_cnt;
   int pe_cnt;
   int lat_bad;
   logic [7:0] got_data;
   logic tv_prev;
   logic half_prev;

   logic [3:0] pcnt;

   uart_rx_deframer #(
      .DATA_BITS   (8),
      .STOP_BITS   (1),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .pre_en        (pre_en),
      .pre_stb       (pre_stb),
      .pre_half      (pre_half),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .frame_err     (frame_err),
      .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_odd    (parity_odd),
      .parity_err    (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Prescaler model, div = 16.
   always @(posedge clk) begin
      if (rst || !pre_en) pcnt <= 4'd0;
      else                pcnt <= pcnt + 4'd1;
   end
   assign pre_half = (pcnt == 4'd7);
   assign pre_stb  = (pcnt == 4'd15);

   // Event monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_axis_tvalid) vcyc++;
         if (m_axis_tvalid && m_axis_tready) begin
            got_cnt++;
            got_data = m_axis_tdata;
         end
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) pe_cnt++;
`endif
         if (m_axis_tvalid && !tv_prev && !half_prev) lat_bad++;
      end
      tv_prev   = m_axis_tvalid;
      half_prev = pre_half;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic v);
      rxd = v;
      tick(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par_force ? par_v : ^d);
`endif
      send_bit(stop_v);
      rxd = 1'b1;
      tick(8);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rxd = 1'b1;
      m_axis_tready = 1'b1;
      tick(4);
      checks++; if (pre_en !== 1'b0) begin failures++; $display("FAIL reset_pre_en got=%b exp=0", pre_en); end
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata got=%h exp=00", m_axis_tdata); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_nominal;
      int g0, v0, f0, o0;
      g0 = got_cnt; v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      m_axis_tready = 1'b1;
      send_frame(8'hA5, 1'b1);
      checks++; if (got_cnt - g0 !== 1) begin failures++; $display("FAIL nominal_count got=%0d exp=1", got_cnt - g0); end
      checks++; if (got_data !== 8'hA5) begin failures++; $display("FAIL nominal_data got=%h exp=a5", got_data); end
      checks++; if (vcyc - v0 !== 1) begin failures++; $display("FAIL nominal_tvalid_cycles got=%0d exp=1", vcyc - v0); end
      checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL nominal_frame_err got=%0d exp=0", fe_cnt - f0); end
      checks++; if (ov_cnt - o0 !== 0) begin failures++; $display("FAIL nominal_overrun got=%0d exp=0", ov_cnt - o0); end
      checks++; if (pre_en !== 1'b0) begin failures++; $display("FAIL nominal_pre_en_idle got=%b exp=0", pre_en); end
      checks++; if (lat_bad !== 0) begin failures++; $display("FAIL nominal_latency got=%0d exp=0", lat_bad); end
   endtask

   task automatic test_glitch;
      int g0, v0, f0;
      g0 = got_cnt; v0 = vcyc; f0 = fe_cnt;
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(1);
      checks++; if (pre_en !== 1'b1) begin failures++; $display("FAIL glitch_pre_en_start got=%b exp=1", pre_en); end
      tick(30);
      checks++; if (pre_en !== 1'b0) begin failures++; $display("FAIL glitch_back_idle got=%b exp=0", pre_en); end
      checks++; if (vcyc - v0 !== 0) begin failures++; $display("FAIL glitch_tvalid got=%0d exp=0", vcyc - v0); end
      checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - f0); end
      checks++; if (got_cnt - g0 !== 0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", got_cnt - g0); end
   endtask

   task automatic test_framing;
      int g0, v0, f0;
      g0 = got_cnt; v0 = vcyc; f0 = fe_cnt;
      m_axis_tready = 1'b1;
      send_frame(8'h3C, 1'b0);
      checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL framing_pulse got=%0d exp=1", fe_cnt - f0); end
      checks++; if (vcyc - v0 !== 0) begin failures++; $display("FAIL framing_tvalid got=%0d exp=0", vcyc - v0); end
      send_frame(8'h5A, 1'b1);
      checks++; if (got_cnt - g0 !== 1) begin failures++; $display("FAIL framing_next_count got=%0d exp=1", got_cnt - g0); end
      checks++; if (got_data !== 8'h5A) begin failures++; $display("FAIL framing_next_data got=%h exp=5a", got_data); end
      checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL framing_no_extra got=%0d exp=1", fe_cnt - f0); end
   endtask

   task automatic test_overrun;
      int g0, o0;
      g0 = got_cnt; o0 = ov_cnt;
      m_axis_tready = 1'b0;
      send_frame(8'h11, 1'b1);
      checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL overrun_first_valid got=%b exp=1", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 8'h11) begin failures++; $display("FAIL overrun_first_data got=%h exp=11", m_axis_tdata); end
      checks++; if (ov_cnt - o0 !== 0) begin failures++; $display("FAIL overrun_early got=%0d exp=0", ov_cnt - o0); end
      send_frame(8'h22, 1'b1);
      checks++; if (ov_cnt - o0 !== 1) begin failures++; $display("FAIL overrun_pulse got=%0d exp=1", ov_cnt - o0); end
      checks++; if (m_axis_tdata !== 8'h11) begin failures++; $display("FAIL overrun_hold_data got=%h exp=11", m_axis_tdata); end
      checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL overrun_hold_valid got=%b exp=1", m_axis_tvalid); end
      m_axis_tready = 1'b1;
      tick(1);
      checks++; if (got_cnt - g0 !== 1) begin failures++; $display("FAIL overrun_accept_count got=%0d exp=1", got_cnt - g0); end
      checks++; if (got_data !== 8'h11) begin failures++; $display("FAIL overrun_accept_data got=%h exp=11", got_data); end
      tick(1);
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL overrun_cleared got=%b exp=0", m_axis_tvalid); end
   endtask

   task automatic test_reset_mid;
      int g0, f0;
      m_axis_tready = 1'b0;
      send_frame(8'h55, 1'b1);
      checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL rstmid_preload got=%b exp=1", m_axis_tvalid); end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      rxd = 1'b1;
      tick(8);
      rst = 1'b1;
      tick(1);
      checks++; if (pre_en !== 1'b0) begin failures++; $display("FAIL rstmid_pre_en got=%b exp=0", pre_en); end
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
      rst = 1'b0;
      g0 = got_cnt; f0 = fe_cnt;
      tick(120);
      checks++; if (got_cnt - g0 !== 0 || m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_no_partial got=%0d/%b exp=0/0", got_cnt - g0, m_axis_tvalid); end
      checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL rstmid_no_error got=%0d exp=0", fe_cnt - f0); end
      m_axis_tready = 1'b1;
      send_frame(8'h81, 1'b1);
      checks++; if (got_cnt - g0 !== 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", got_cnt - g0); end
      checks++; if (got_data !== 8'h81) begin failures++; $display("FAIL rstmid_next_data got=%h exp=81", got_data); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int g0, v0, p0;
      parity_odd = 1'b0;
      par_force = 1'b1;
      m_axis_tready = 1'b1;
      g0 = got_cnt; p0 = pe_cnt;
      par_v = 1'b1;
      send_frame(8'h07, 1'b1);
      checks++; if (got_cnt - g0 !== 1) begin failures++; $display("FAIL parity_ok_count got=%0d exp=1", got_cnt - g0); end
      checks++; if (got_data !== 8'h07) begin failures++; $display("FAIL parity_ok_data got=%h exp=07", got_data); end
      checks++; if (pe_cnt - p0 !== 0) begin failures++; $display("FAIL parity_ok_err got=%0d exp=0", pe_cnt - p0); end
      v0 = vcyc;
      par_v = 1'b0;
      send_frame(8'h07, 1'b1);
      checks++; if (pe_cnt - p0 !== 1) begin failures++; $display("FAIL parity_bad_pulse got=%0d exp=1", pe_cnt - p0); end
      checks++; if (vcyc - v0 !== 0) begin failures++; $display("FAIL parity_bad_tvalid got=%0d exp=0", vcyc - v0); end
      par_force = 1'b0;
   endtask
`endif

   initial begin
      checks = 0; failures = 0;
      got_cnt = 0; vcyc = 0; fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; lat_bad = 0;
      got_data = 8'h00; tv_prev = 1'b0; half_prev = 1'b0;
      rst = 1'b1; rxd = 1'b1; m_axis_tready = 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0; par_force = 1'b0; par_v = 1'b0;
`endif
      test_reset;
      test_nominal;
      test_glitch;
      test_framing;
      test_overrun;
      test_reset_mid;
`ifdef UART_RX_PARITY_EN
      test_parity;
`endif
      checks++; if (lat_bad !== 0) begin failures++; $display("FAIL final_latency got=%0d exp=0", lat_bad); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
